// File: rtl/mezclador_bandas_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mezclador_bandas_if: band samples, gains and mixed-sample result bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface mezclador_bandas_if #(
  parameter int DATA_W = 23,
  parameter int GAIN_W = 8
);
  logic                     enable;
  logic signed [DATA_W-1:0] Data_In_bajos;
  logic signed [DATA_W-1:0] Data_In_medios;
  logic signed [DATA_W-1:0] Data_In_altos;
  logic        [GAIN_W-1:0] Gain_bajos;
  logic        [GAIN_W-1:0] Gain_medios;
  logic        [GAIN_W-1:0] Gain_altos;
  logic signed [DATA_W-1:0] Data_Out;
  logic                     Data_Valid;
  logic                     Busy;
  logic                     Sat_Flag;

  modport master (
    output enable, Data_In_bajos, Data_In_medios, Data_In_altos,
           Gain_bajos, Gain_medios, Gain_altos,
    input  Data_Out, Data_Valid, Busy, Sat_Flag
  );

  modport slave (
    input  enable, Data_In_bajos, Data_In_medios, Data_In_altos,
           Gain_bajos, Gain_medios, Gain_altos,
    output Data_Out, Data_Valid, Busy, Sat_Flag
  );
endinterface
`default_nettype wire

// File: rtl/mezclador_bandas.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mezclador_bandas: three-band gain/mix stage, one shared multiplier, saturating
// Rev 1.0
// ---------------------------------------------------------------------------
module mezclador_bandas #(
  parameter int DATA_W    = 23,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6,
  parameter int ACC_W     = 34
) (
  input  logic               clock_In,
  input  logic               Reset,
  mezclador_bandas_if.slave  bus
);
  localparam int c_prod_w = DATA_W + GAIN_W + 1;

  localparam logic signed [ACC_W-1:0] c_max =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_min =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_B = 3'd1,
    S_MUL_M = 3'd2,
    S_MUL_A = 3'd3,
    S_SAT   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_busy;

  logic signed [DATA_W-1:0]   r_smp_b, r_smp_m, r_smp_a;
  logic        [GAIN_W-1:0]   r_gain_b, r_gain_m, r_gain_a;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [DATA_W-1:0]   r_data_out;
  logic                       r_valid;
  logic                       r_sat;

  logic signed [DATA_W-1:0]   w_smp;
  logic        [GAIN_W-1:0]   w_gain;
  logic signed [c_prod_w-1:0] w_smp_x;
  logic signed [c_prod_w-1:0] w_gain_x;
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_shift;
  logic                       w_hi;
  logic                       w_lo;

  always_ff @(posedge clock_In) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.enable) w_state_next = S_MUL_B;
      end
      S_MUL_B: w_state_next = S_MUL_M;
      S_MUL_M: w_state_next = S_MUL_A;
      S_MUL_A: w_state_next = S_SAT;
      S_SAT:   w_state_next = S_IDLE;
      default: begin
        w_state_next = S_IDLE;
        w_busy       = 1'b0;
      end
    endcase
  end

  // The multiplier is shared: the state selects which latched band feeds it.
  always_comb begin
    w_smp  = r_smp_b;
    w_gain = r_gain_b;
    case (r_state)
      S_MUL_M: begin
        w_smp  = r_smp_m;
        w_gain = r_gain_m;
      end
      S_MUL_A: begin
        w_smp  = r_smp_a;
        w_gain = r_gain_a;
      end
      default: ;
    endcase
  end

  assign w_smp_x    = {{(c_prod_w-DATA_W){w_smp[DATA_W-1]}}, w_smp};
  assign w_gain_x   = {{(c_prod_w-GAIN_W){1'b0}}, w_gain};
  assign w_prod     = w_smp_x * w_gain_x;
  assign w_prod_ext = {{(ACC_W-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};

  // Arithmetic shift drops the Q2.6 fraction, rounding toward minus infinity.
  assign w_shift = r_acc >>> GAIN_FRAC;
  assign w_hi    = (w_shift > c_max);
  assign w_lo    = (w_shift < c_min);

  always_ff @(posedge clock_In) begin
    if (Reset) begin
      r_smp_b    <= '0;
      r_smp_m    <= '0;
      r_smp_a    <= '0;
      r_gain_b   <= '0;
      r_gain_m   <= '0;
      r_gain_a   <= '0;
      r_acc      <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_smp_b  <= bus.Data_In_bajos;
            r_smp_m  <= bus.Data_In_medios;
            r_smp_a  <= bus.Data_In_altos;
            r_gain_b <= bus.Gain_bajos;
            r_gain_m <= bus.Gain_medios;
            r_gain_a <= bus.Gain_altos;
            r_acc    <= '0;
          end
        end
        S_MUL_B, S_MUL_M, S_MUL_A: r_acc <= r_acc + w_prod_ext;
        S_SAT: begin
          r_valid <= 1'b1;
          r_sat   <= w_hi | w_lo;
          if (w_hi)      r_data_out <= c_max[DATA_W-1:0];
          else if (w_lo) r_data_out <= c_min[DATA_W-1:0];
          else           r_data_out <= w_shift[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.Data_Out   = r_data_out;
  assign bus.Data_Valid = r_valid;
  assign bus.Busy       = w_busy;
  assign bus.Sat_Flag   = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_mezclador_bandas.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mezclador_bandas: vector table, random samples vs. arithmetic model, corner sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mezclador_bandas;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mezclador_bandas_if #(.DATA_W(23), .GAIN_W(8)) bus ();

  mezclador_bandas #(
    .DATA_W(23), .GAIN_W(8), .GAIN_FRAC(6), .ACC_W(34)
  ) dut (
    .clock_In(clk),
    .Reset   (rst),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int b, m, a;
    int gb, gm, ga;
    int exp_out;
    bit exp_sat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mix = floor((sum of sample*gain) / 64), then clamped to the 23-bit range.
  function automatic void model(input int b, m, a, gb, gm, ga,
                                output int out, output bit sat);
    longint s;
    longint q;
    s = longint'(b) * gb + longint'(m) * gm + longint'(a) * ga;
    if (s >= 0) q = s / 64;
    else        q = -((-s + 63) / 64);
    if (q > 4194303)       begin out = 4194303;  sat = 1'b1; end
    else if (q < -4194304) begin out = -4194304; sat = 1'b1; end
    else                   begin out = int'(q);  sat = 1'b0; end
  endfunction

  task automatic drive(input int b, m, a, gb, gm, ga, input bit en);
    bus.Data_In_bajos  = 23'(b);
    bus.Data_In_medios = 23'(m);
    bus.Data_In_altos  = 23'(a);
    bus.Gain_bajos     = 8'(gb);
    bus.Gain_medios    = 8'(gm);
    bus.Gain_altos     = 8'(ga);
    bus.enable         = en;
  endtask

  task automatic scramble();
    drive(int'($urandom), int'($urandom), int'($urandom),
          int'($urandom), int'($urandom), int'($urandom), 1'b0);
  endtask

  task automatic run_sample(input string name, input int b, m, a, gb, gm, ga,
                            input int exp_out, input bit exp_sat);
    int lat;
    bit seen;
    @(negedge clk);
    drive(b, m, a, gb, gm, ga, 1'b1);
    @(posedge clk); #1;
    scramble();
    check({name, " busy"}, bus.Busy, 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      seen = bus.Data_Valid;
    end
    check({name, " latency"}, lat, 4);
    check({name, " out"}, bus.Data_Out, exp_out);
    check({name, " sat"}, bus.Sat_Flag, exp_sat);
    check({name, " busy end"}, bus.Busy, 0);
    @(posedge clk); #1;
    check({name, " valid pulse"}, bus.Data_Valid, 0);
    check({name, " out hold"}, bus.Data_Out, exp_out);
    check({name, " sat hold"}, bus.Sat_Flag, exp_sat);
  endtask

  initial begin
    int eo, ea, ec;
    bit es, sa, sc;
    int b, m, a, gb, gm, ga;

    vecs.push_back('{100, 200, 300, 64, 64, 64, 600, 1'b0});
    vecs.push_back('{1000, -500, -64, 128, 0, 32, 1968, 1'b0});
    vecs.push_back('{5, 7, -1, 0, 0, 32, -1, 1'b0});
    vecs.push_back('{5, 7, 1, 0, 0, 32, 0, 1'b0});
    vecs.push_back('{4194303, 4194303, 4194303, 255, 255, 255, 4194303, 1'b1});
    vecs.push_back('{-4194304, -4194304, -4194304, 255, 255, 255, -4194304, 1'b1});
    vecs.push_back('{4194303, 0, 0, 64, 0, 0, 4194303, 1'b0});
    vecs.push_back('{-4194304, 0, 0, 64, 0, 0, -4194304, 1'b0});
    vecs.push_back('{4194303, 0, 0, 65, 0, 0, 4194303, 1'b1});
    vecs.push_back('{-4194304, 0, 0, 65, 0, 0, -4194304, 1'b1});
    vecs.push_back('{1, 0, 0, 255, 0, 0, 3, 1'b0});
    vecs.push_back('{0, -1, 0, 0, 255, 0, -4, 1'b0});

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset out", bus.Data_Out, 0);
    check("reset valid", bus.Data_Valid, 0);
    check("reset busy", bus.Busy, 0);
    check("reset sat", bus.Sat_Flag, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_sample($sformatf("vec%0d", i), vecs[i].b, vecs[i].m, vecs[i].a,
                 vecs[i].gb, vecs[i].gm, vecs[i].ga, vecs[i].exp_out, vecs[i].exp_sat);

    for (int i = 0; i < 60; i++) begin
      b  = int'($urandom_range(0, 8388607)) - 4194304;
      m  = int'($urandom_range(0, 8388607)) - 4194304;
      a  = int'($urandom_range(0, 8388607)) - 4194304;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 4194303 : -4194304;
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 255)) - 128;
      gb = int'($urandom_range(0, 255));
      gm = int'($urandom_range(0, 255));
      ga = int'($urandom_range(0, 255));
      model(b, m, a, gb, gm, ga, eo, es);
      run_sample($sformatf("rand%0d", i), b, m, a, gb, gm, ga, eo, es);
    end

    // Enables at N, N+2 (dropped while busy) and N+5 (back-to-back).
    model(1111, -2222, 3333, 70, 90, 110, ea, sa);
    model(-5000, 6000, -7000, 200, 10, 255, ec, sc);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0)      drive(1111, -2222, 3333, 70, 90, 110, 1'b1);
      else if (c == 2) drive(99999, 99999, 99999, 255, 255, 255, 1'b1);
      else if (c == 5) drive(-5000, 6000, -7000, 200, 10, 255, 1'b1);
      else             scramble();
      @(posedge clk); #1;
      check($sformatf("b2b valid c%0d", c), bus.Data_Valid, (c == 4 || c == 9) ? 1 : 0);
      check($sformatf("b2b busy c%0d", c), bus.Busy, (c == 4 || c >= 9) ? 0 : 1);
      if (c >= 4 && c < 9) check($sformatf("b2b out A c%0d", c), bus.Data_Out, ea);
      if (c == 4) check("b2b sat A", bus.Sat_Flag, sa);
      if (c == 9) begin
        check("b2b out C", bus.Data_Out, ec);
        check("b2b sat C", bus.Sat_Flag, sc);
      end
    end
    @(negedge clk);
    scramble();

    // Leave nonzero outputs behind, then reset two edges into a new sample.
    run_sample("pre reset", 4194303, 4194303, 0, 255, 255, 0, 4194303, 1'b1);
    @(negedge clk);
    drive(500, 500, 500, 64, 64, 64, 1'b1);
    @(posedge clk); #1;
    scramble();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst out", bus.Data_Out, 0);
    check("midrst valid", bus.Data_Valid, 0);
    check("midrst busy", bus.Busy, 0);
    check("midrst sat", bus.Sat_Flag, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("midrst no valid c%0d", c), bus.Data_Valid, 0);
      check($sformatf("midrst idle c%0d", c), bus.Busy, 0);
    end
    model(-123456, 654321, 777, 17, 99, 201, eo, es);
    run_sample("post reset", -123456, 654321, 777, 17, 99, 201, eo, es);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/mezclador_bandas.md
Name: mezclador_bandas

Overview:
Equalizer gain/mix stage placed directly downstream of the three-band filter stage (bajos/medios/altos outputs). On each sample strobe it captures the three 23-bit band samples and weights each by its own unsigned gain. It sums the three weighted bands and produces one saturated 23-bit mixed sample for the output/DAC path. A single shared multiplier is time-multiplexed over the three bands under a small FSM.

Parameters:
DATA_W, 23, sample width; band inputs and output are signed two's complement.
GAIN_W, 8, gain width; gains are unsigned.
GAIN_FRAC, 6, fractional bits of gain (Q2.6); a gain of 64 = 1.0, max gain 255 = 3.984.
ACC_W, 34, accumulator width; signed.

Ports:
clock_In  input  1  system clock; all logic on its rising edge
Reset  input  1  synchronous, active-high reset
enable  input  1  sample strobe, in the same sense as the filter stage's enable
Data_In_bajos  input  23  signed low-band sample
Data_In_medios  input  23  signed mid-band sample
Data_In_altos  input  23  signed high-band sample
Gain_bajos  input  8  unsigned low-band gain
Gain_medios  input  8  unsigned mid-band gain
Gain_altos  input  8  unsigned high-band gain
Data_Out  output  23  signed mixed sample, registered
Data_Valid  output  1  one-cycle pulse when Data_Out is updated
Busy  output  1  high while a sample is being processed
Sat_Flag  output  1  valid with Data_Valid; 1 if the result was clamped

Behaviour:
- Reset (synchronous, Reset=1 at the rising edge):
  - Data_Out=0, Data_Valid=0, Busy=0, Sat_Flag=0.
  - Accumulator=0, FSM=IDLE.
  - Reset has priority over enable.
  - Reset mid-operation aborts the sample with no Data_Valid pulse.
- FSM states: IDLE, MUL_B, MUL_M, MUL_A, SAT.
- IDLE:
  - If enable=1 at edge N: latch the 3 samples and 3 gains into internal registers, clear the accumulator, go to MUL_B, Busy=1.
  - Otherwise stay in IDLE.
- MUL_B, edge N+1: acc = acc + sx(bajos) * zx(Gain_bajos), where sx = sign-extend and zx = zero-extend to a 9-bit signed gain. Go to MUL_M.
- MUL_M, edge N+2: same operation with the medios sample and gain. Go to MUL_A.
- MUL_A, edge N+3: same operation with the altos sample and gain. Go to SAT.
- SAT, edge N+4:
  - r = acc >>> GAIN_FRAC (arithmetic shift, i.e. truncation toward minus infinity).
  - If r > 4194303: Data_Out=4194303, Sat_Flag=1.
  - Else if r < -4194304: Data_Out=-4194304, Sat_Flag=1.
  - Else: Data_Out=r[22:0], Sat_Flag=0.
  - Data_Valid=1 for exactly one cycle. Busy=0. Go to IDLE.
- Latency is 4 clocks from the edge that samples enable to the edge that updates Data_Out. Throughput is at most one sample per 5 clocks.
- enable=1 while Busy=1 is ignored entirely: no queuing, and latched operands are unchanged.
- enable is accepted again at the edge immediately after SAT (back-to-back operation).
- Data_Out holds its value between updates. Sat_Flag holds until the next SAT edge or Reset.
- Input ports may change freely after the accepting edge; only latched copies are used.
- Width rules:
  - Each product fits 32 bits signed.
  - The sum of 3 products fits ACC_W=34 bits, so the accumulator never wraps.
  - Saturation is applied only once, at the final stage; intermediate terms are never clamped.

Test Plan:
- Unity gains: gains 64/64/64, samples 100/200/300, enable pulse → after 4 clocks Data_Out=600, Data_Valid one cycle, Sat_Flag=0.
- Mixed gains and signs: gains 128/0/32, samples 1000/-500/-64 → Data_Out=1968 (sum 125952 >>> 6), Sat_Flag=0.
- Truncation: gains 0/0/32, altos=-1 → Data_Out=-1 (floor of -0.5). With altos=+1 → Data_Out=0.
- Saturation:
  - All samples 4194303, gains 255 → Data_Out=4194303, Sat_Flag=1.
  - All samples -4194304, gains 255 → Data_Out=-4194304, Sat_Flag=1.
- Busy/back-to-back:
  - Pulse enable at edges N, N+2 and N+5 with differing samples.
  - Edge N+2 is ignored (Busy=1).
  - Data_Valid at N+4 reflects the N operands. Data_Valid at N+9 reflects the N+5 operands.
- Reset mid-operation: assert Reset at edge N+2 of a sample → all outputs 0, FSM IDLE, no Data_Valid pulse. A new enable after Reset deasserts completes normally.
